// File: rtl/loop_trx_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing the transceiver TX write port between
// N_REQ sources, with a stall watchdog that revokes a grant whose owner goes silent.
module loop_trx_tx_arbiter #(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 34,
  parameter int TIMEOUT = 255
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*DATA_W-1:0]   i_data,
  input  logic [N_REQ-1:0]          i_last,
  output logic [N_REQ-1:0]          o_ack,
  output logic [N_REQ-1:0]          o_grant,
  input  logic                      i_trx_rdy,
  output logic [DATA_W-1:0]         o_trx,
  output logic                      o_trx_wr,
  output logic                      o_busy,
  output logic [7:0]                o_err_cnt
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_WAIT  = 3'b010,
    S_WRITE = 3'b100
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_last;
  logic [IW-1:0]     r_gidx;
  logic              r_beat_last;
  logic [TW-1:0]     r_timer;

  logic              w_any;
  logic [IW-1:0]     w_sel;
  logic              w_own_req;
  logic              w_own_last;
  logic [DATA_W-1:0] w_own_data;

  // Scan r_last+N down to r_last+1 so the earliest set bit in round-robin order wins.
  always_comb begin
    w_sel = r_last;
    w_any = |i_req;
    for (int i = N_REQ; i >= 1; i--) begin
      if (i_req[(int'(r_last) + i) % N_REQ])
        w_sel = IW'((int'(r_last) + i) % N_REQ);
    end
  end

  assign w_own_req  = i_req[r_gidx];
  assign w_own_last = i_last[r_gidx];
  assign w_own_data = i_data[int'(r_gidx)*DATA_W +: DATA_W];

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state     <= S_IDLE;
      r_last      <= LAST_INIT;
      r_gidx      <= '0;
      r_beat_last <= 1'b0;
      r_timer     <= '0;
      o_ack       <= '0;
      o_grant     <= '0;
      o_trx       <= '0;
      o_trx_wr    <= 1'b0;
      o_busy      <= 1'b0;
      o_err_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_trx_wr <= 1'b0;
          o_ack    <= '0;
          if (w_any) begin
            r_gidx  <= w_sel;
            o_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
            o_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_own_req && i_trx_rdy) begin
            o_trx       <= w_own_data;
            r_beat_last <= w_own_last;
            r_timer     <= '0;
            o_trx_wr    <= 1'b1;
            o_ack       <= o_grant;
            r_state     <= S_WRITE;
          end else if (!w_own_req && (TIMEOUT != 0)) begin
            if (r_timer == TO_LAST) begin
              // Owner went silent mid-packet: drop it and let the others in.
              r_timer <= '0;
              r_last  <= r_gidx;
              o_grant <= '0;
              o_busy  <= 1'b0;
              r_state <= S_IDLE;
              if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end else begin
            // Backpressure from the transceiver is not a stall.
            r_timer <= '0;
          end
        end
        S_WRITE: begin
          o_trx_wr <= 1'b0;
          o_ack    <= '0;
          if (r_beat_last) begin
            r_last  <= r_gidx;
            o_grant <= '0;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_timer  <= '0;
          o_grant  <= '0;
          o_busy   <= 1'b0;
          o_trx_wr <= 1'b0;
          o_ack    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_trx_tx_arbiter.sv
// Directed bench for loop_trx_tx_arbiter: per-cycle vector table plus hand-written
// backpressure, watchdog and mid-packet reset sequences.
module tb_loop_trx_tx_arbiter;
  localparam int N = 2;
  localparam int W = 34;

  logic         clk = 1'b0;
  logic         arst_n;
  logic [N-1:0] req, last, ack, grant;
  logic [W-1:0] d0, d1, trx;
  logic         rdy, wr, busy;
  logic [7:0]   err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  loop_trx_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_req(req), .i_data({d1, d0}), .i_last(last),
    .o_ack(ack), .o_grant(grant), .i_trx_rdy(rdy), .o_trx(trx), .o_trx_wr(wr),
    .o_busy(busy), .o_err_cnt(err)
  );

  typedef struct {
    bit           rst;
    logic [N-1:0] req, last;
    logic         rdy;
    logic [W-1:0] d0, d1;
    logic [N-1:0] e_grant, e_ack;
    logic         e_wr, e_busy;
    logic [W-1:0] e_trx;
  } vec_t;

  vec_t tv[$];

  localparam logic [W-1:0] D1 = 34'h1_2345_6789;
  localparam logic [W-1:0] D2 = 34'h2_AAAA_5555;
  localparam logic [W-1:0] A  = 34'h0_0000_00A0;
  localparam logic [W-1:0] B  = 34'h3_0000_00B0;
  localparam logic [W-1:0] B2 = 34'h3_0000_00B2;
  localparam logic [W-1:0] B3 = 34'h3_0000_00B3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    req = '0; last = '0; rdy = 1'b0; d0 = '0; d1 = '0;
    #12;
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic add(input bit r, input logic [1:0] rq, input logic [1:0] ls, input logic rd,
                     input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [1:0] eg,
                     input logic [1:0] ea, input logic ew, input logic eb,
                     input logic [W-1:0] et);
    vec_t v;
    v.rst = r; v.req = rq; v.last = ls; v.rdy = rd; v.d0 = a0; v.d1 = a1;
    v.e_grant = eg; v.e_ack = ea; v.e_wr = ew; v.e_busy = eb; v.e_trx = et;
    tv.push_back(v);
  endtask

  initial begin
    //   rst req    last   rdy d0  d1  grant  ack    wr  busy trx
    // T1: single 2-beat packet from requester 0
    add(1, 2'b01, 2'b00, 1, D1, 0,  2'b01, 2'b00, 0, 1, 0);
    add(0, 2'b01, 2'b00, 1, D1, 0,  2'b01, 2'b01, 1, 1, D1);
    add(0, 2'b01, 2'b00, 1, D1, 0,  2'b01, 2'b00, 0, 1, D1);
    add(0, 2'b01, 2'b01, 1, D2, 0,  2'b01, 2'b01, 1, 1, D2);
    add(0, 2'b01, 2'b01, 1, D2, 0,  2'b00, 2'b00, 0, 0, D2);
    add(0, 2'b00, 2'b00, 1, 0,  0,  2'b00, 2'b00, 0, 0, D2);
    // T2: both requesting 1-beat packets, grants alternate starting with 0
    add(1, 2'b11, 2'b11, 1, A,  B,  2'b01, 2'b00, 0, 1, 0);
    add(0, 2'b11, 2'b11, 1, A,  B,  2'b01, 2'b01, 1, 1, A);
    add(0, 2'b11, 2'b11, 1, A,  B,  2'b00, 2'b00, 0, 0, A);
    add(0, 2'b11, 2'b11, 1, A,  B,  2'b10, 2'b00, 0, 1, A);
    add(0, 2'b11, 2'b11, 1, A,  B,  2'b10, 2'b10, 1, 1, B);
    add(0, 2'b11, 2'b11, 1, A,  B,  2'b00, 2'b00, 0, 0, B);
    add(0, 2'b11, 2'b11, 1, A,  B,  2'b01, 2'b00, 0, 1, B);
    add(0, 2'b11, 2'b11, 1, A,  B,  2'b01, 2'b01, 1, 1, A);
    add(0, 2'b11, 2'b11, 1, A,  B,  2'b00, 2'b00, 0, 0, A);
    add(0, 2'b11, 2'b11, 1, A,  B,  2'b10, 2'b00, 0, 1, A);
    add(0, 2'b11, 2'b11, 1, A,  B,  2'b10, 2'b10, 1, 1, B);
    add(0, 2'b11, 2'b11, 1, A,  B,  2'b00, 2'b00, 0, 0, B);
    // T3: requester 1 3-beat packet, requester 0 joins at beat 1 and must wait
    add(1, 2'b10, 2'b00, 1, A,  B,  2'b10, 2'b00, 0, 1, 0);
    add(0, 2'b11, 2'b01, 1, A,  B,  2'b10, 2'b10, 1, 1, B);
    add(0, 2'b11, 2'b01, 1, A,  B,  2'b10, 2'b00, 0, 1, B);
    add(0, 2'b11, 2'b01, 1, A,  B2, 2'b10, 2'b10, 1, 1, B2);
    add(0, 2'b11, 2'b01, 1, A,  B2, 2'b10, 2'b00, 0, 1, B2);
    add(0, 2'b11, 2'b11, 1, A,  B3, 2'b10, 2'b10, 1, 1, B3);
    add(0, 2'b11, 2'b11, 1, A,  B3, 2'b00, 2'b00, 0, 0, B3);
    add(0, 2'b01, 2'b01, 1, A,  0,  2'b01, 2'b00, 0, 1, B3);
    add(0, 2'b01, 2'b01, 1, A,  0,  2'b01, 2'b01, 1, 1, A);
    add(0, 2'b00, 2'b00, 1, A,  0,  2'b00, 2'b00, 0, 0, A);

    do_reset();
    chk("rst grant", 64'(grant), 64'(0));
    chk("rst busy",  64'(busy),  64'(0));
    chk("rst wr",    64'(wr),    64'(0));
    chk("rst trx",   64'(trx),   64'(0));
    chk("rst err",   64'(err),   64'(0));

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      req = tv[i].req; last = tv[i].last; rdy = tv[i].rdy; d0 = tv[i].d0; d1 = tv[i].d1;
      step();
      chk($sformatf("vec%0d grant", i), 64'(grant), 64'(tv[i].e_grant));
      chk($sformatf("vec%0d ack", i),   64'(ack),   64'(tv[i].e_ack));
      chk($sformatf("vec%0d wr", i),    64'(wr),    64'(tv[i].e_wr));
      chk($sformatf("vec%0d busy", i),  64'(busy),  64'(tv[i].e_busy));
      chk($sformatf("vec%0d trx", i),   64'(trx),   64'(tv[i].e_trx));
    end

    // T4: long backpressure never times out, beat goes out the cycle after rdy
    do_reset();
    req = 2'b01; last = 2'b01; d0 = D1; rdy = 1'b0;
    step();
    begin
      int wr_seen = 0;
      for (int c = 0; c < 500; c++) begin
        step();
        if (wr || grant != 2'b01) wr_seen++;
      end
      chk("bp wr/grant disturbed", 64'(wr_seen), 64'(0));
    end
    chk("bp err", 64'(err), 64'(0));
    rdy = 1'b1;
    step();
    chk("bp wr", 64'(wr), 64'(1));
    chk("bp trx", 64'(trx), 64'(D1));
    chk("bp ack", 64'(ack), 64'(2'b01));

    // T5: owner stalls after beat 1 of 2, watchdog revokes after 16 idle cycles
    do_reset();
    req = 2'b01; last = 2'b00; d0 = D1; d1 = B; rdy = 1'b1;
    step();
    step();
    chk("wd beat1 wr", 64'(wr), 64'(1));
    step();
    req = 2'b10; last = 2'b10;
    for (int c = 0; c < 15; c++) step();
    chk("wd grant held", 64'(grant), 64'(2'b01));
    chk("wd err early", 64'(err), 64'(0));
    step();
    chk("wd revoked", 64'(grant), 64'(2'b00));
    chk("wd err", 64'(err), 64'(1));
    step();
    chk("wd next grant", 64'(grant), 64'(2'b10));
    step();
    chk("wd next trx", 64'(trx), 64'(B));

    // T6: asynchronous reset in the middle of a packet
    do_reset();
    req = 2'b01; last = 2'b00; d0 = D1; rdy = 1'b1;
    step();
    step();
    step();
    rdy = 1'b0; d0 = D2; last = 2'b01;
    step();
    #2;
    arst_n = 1'b0;
    #1;
    chk("mid rst grant", 64'(grant), 64'(0));
    chk("mid rst busy",  64'(busy),  64'(0));
    chk("mid rst trx",   64'(trx),   64'(0));
    rdy = 1'b1;
    step();
    chk("mid rst wr", 64'(wr), 64'(0));
    req = 2'b11; last = 2'b11; d1 = B;
    @(negedge clk);
    arst_n = 1'b1;
    step();
    chk("post rst grant", 64'(grant), 64'(2'b01));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
